cntr_mod: RTL and testbench

CNTR_MOD -- requirements
Module: cntr_mod

---
 rtl/cntr_pkg.sv | 13 +
 rtl/cntr_mod.sv | 50 +++++
 tb/tb_cntr_mod.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cntr_pkg.sv
// cntr_pkg: terminal-mode constants and next-count rule shared by modulo counters
package cntr_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Next count within [0, m-1]; saturating mode holds at either terminal value.
    function automatic int next_cnt(int o, logic up, int m, int mode);
        return up ? ((o == m - 1) ? ((mode == MODE_SAT) ? o : 0) : o + 1)
                  : ((o == 0) ? ((mode == MODE_SAT) ? o : m - 1) : o - 1);
    endfunction

endpackage

// File: rtl/cntr_mod.sv
// cntr_mod: up/down modulo-MOD counter with load clamp, wrap or saturate at terminals,
// combinational terminal-count flag and registered one-cycle wrap pulse
module cntr_mod
    import cntr_pkg::*;
#(
    parameter int W    = 4,
    parameter int MOD  = 16,
    parameter int MODE = MODE_WRAP
) (
    input  logic         c,
    input  logic         r,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] o,
    output logic         tc,
    output logic         wr
);

    if (MOD < 2 || MOD > 2 ** W || (MODE != MODE_WRAP && MODE != MODE_SAT)) begin : g_bad_param
        $error("cntr_mod: illegal parameters MOD=%0d W=%0d MODE=%0d", MOD, W, MODE);
    end

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    // Power-up values give o=0, wr=0 before any reset or clock edge.
    logic [W-1:0] cnt = '0;
    logic         wrp = 1'b0;

    assign o  = cnt;
    assign wr = wrp;
    assign tc = up ? (cnt == TOP) : (cnt == '0);

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            cnt <= '0;
            wrp <= 1'b0;
        end else if (ld) begin
            cnt <= ({1'b0, d} >= (W + 1)'(MOD)) ? TOP : d;
            wrp <= 1'b0;
        end else if (en) begin
            cnt <= W'(next_cnt(int'(cnt), up, MOD, MODE));
            wrp <= (MODE == MODE_WRAP) && tc;
        end else begin
            wrp <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cntr_mod.sv
// tb_cntr_mod: wrap and saturate instances under directed and random stimulus vs an arithmetic model
module tb_cntr_mod;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         c  = 1'b0;
    logic         r  = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] d  = '0;
    logic [W-1:0] o0, o1;
    logic         tc0, tc1, wr0, wr1;

    int checks = 0;
    int errors = 0;
    int m[2];
    bit w[2];

    cntr_mod #(.W(W), .MOD(MOD), .MODE(0)) u_wrap (
        .c(c), .r(r), .en(en), .up(up), .ld(ld), .d(d), .o(o0), .tc(tc0), .wr(wr0)
    );

    cntr_mod #(.W(W), .MOD(MOD), .MODE(1)) u_sat (
        .c(c), .r(r), .en(en), .up(up), .ld(ld), .d(d), .o(o1), .tc(tc1), .wr(wr1)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: index 0 wraps, index 1 saturates; counts are residues mod MOD.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (ld) begin
                m[k] = (int'(d) >= MOD) ? MOD - 1 : int'(d);
                w[k] = 1'b0;
            end else if (en) begin
                bit term;
                term = up ? (m[k] == MOD - 1) : (m[k] == 0);
                w[k] = (k == 0) && term;
                if (!(k == 1 && term)) m[k] = (m[k] + (up ? 1 : MOD - 1)) % MOD;
            end else begin
                w[k] = 1'b0;
            end
        end
    endtask

    function automatic bit tc_exp(int v);
        return up ? (v == MOD - 1) : (v == 0);
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, " o_wrap"}, 32'(o0), m[0]);
        chk({tag, " wr_wrap"}, 32'(wr0), 32'(w[0]));
        chk({tag, " o_sat"}, 32'(o1), m[1]);
        chk({tag, " wr_sat"}, 32'(wr1), 32'(w[1]));
    endtask

    task automatic chk_tc(input string tag);
        chk({tag, " tc_wrap"}, 32'(tc0), 32'(tc_exp(m[0])));
        chk({tag, " tc_sat"}, 32'(tc1), 32'(tc_exp(m[1])));
    endtask

    task automatic cycle(input bit e, input bit u, input bit l, input int dv, input string tag);
        en = e;
        up = u;
        ld = l;
        d  = W'(dv);
        #1;
        chk_tc(tag);
        @(posedge c);
        model_edge();
        #1;
        chk_state(tag);
    endtask

    task automatic areset(input string tag);
        r = 1'b1;
        en = 1'b1;
        ld = 1'b1;
        #1;
        m = '{0, 0};
        w = '{0, 0};
        chk_state(tag);
        r = 1'b0;
        ld = 1'b0;
    endtask

    initial begin
        m = '{0, 0};
        w = '{0, 0};
        #1;
        chk_state("powerup");
        areset("reset");

        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, "up_count");
        chk("up12_value", 32'(o0), 2);

        areset("reset2");
        cycle(1, 0, 0, 0, "down_wrap");
        chk("down_wrap_pulse", 32'(wr0), 1);
        cycle(1, 0, 0, 0, "down8");
        cycle(1, 0, 0, 0, "down7");
        chk("down_value", 32'(o0), 7);

        for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, "sat_hold");
        chk("sat_value", 32'(o1), 9);

        cycle(1, 1, 1, 13, "load_clamp");
        chk("clamp_value", 32'(o0), 9);
        cycle(1, 1, 1, 4, "load4");

        cycle(1, 1, 1, 5, "load5");
        areset("midcount_reset");
        cycle(1, 1, 0, 0, "after_reset");
        chk("after_reset_value", 32'(o0), 1);

        cycle(1, 1, 1, 9, "load9");
        cycle(1, 1, 0, 0, "wrap_pulse");
        areset("midpulse_reset");

        cycle(1, 1, 1, 9, "load9b");
        up = 1'b1;
        #1;
        chk_tc("tc_up");
        cycle(1, 0, 0, 0, "toggle_dir");
        chk("toggle_value", 32'(o0), 8);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) areset("rand_reset");
            cycle($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(7) == 0,
                  int'($urandom_range(15)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
